// File: rtl/descrambler_if.sv
// descrambler_if: receive word stream in, descrambled stream out.
// master drives the link side, slave is the descrambler.
interface descrambler_if #(
    parameter int WIDTH = 16
);
    logic             descram_en;
    logic             in_valid;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             sync_det;
    logic             locked;

    modport master (
        output descram_en,
        output in_valid,
        output in,
        input  out,
        input  out_valid,
        input  sync_det,
        input  locked
    );

    modport slave (
        input  descram_en,
        input  in_valid,
        input  in,
        output out,
        output out_valid,
        output sync_det,
        output locked
    );
endinterface

// File: rtl/descrambler.sv
// descrambler: x^16+x^5+x^4+x^3+1 additive descrambler with
// sync-word reseed and hunt/verify/locked framing.
module descrambler #(
    parameter int               WIDTH         = 16,
    parameter logic [WIDTH-1:0] SYNC_WORD     = 16'hBCBC,
    parameter int               SYNC_INTERVAL = 8,
    parameter int               LOCK_CNT      = 3,
    parameter int               LOSS_CNT      = 2
) (
    input logic          clk,
    input logic          rst_n,
    descrambler_if.slave bus
);
    localparam int CNT_W  = $clog2(SYNC_INTERVAL);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(LOSS_CNT + 1);

    localparam logic [WIDTH-1:0]  SEED = '1;
    localparam logic [WIDTH-1:0]  TAPS = WIDTH'(16'h0039);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SYNC_INTERVAL - 1);
    localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_CNT);
    localparam logic [MISS_W-1:0] MISS_LOSS = MISS_W'(LOSS_CNT);

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } state_t;

    logic [WIDTH-1:0]  in_reg;
    logic              v_reg;
    logic              en_reg;
    logic [WIDTH-1:0]  s;
    logic [WIDTH-1:0]  s_adv;
    logic [WIDTH-1:0]  ks;
    logic [CNT_W-1:0]  cnt;
    logic [GOOD_W-1:0] good_q;
    logic [GOOD_W-1:0] good_d;
    logic [MISS_W-1:0] miss_q;
    logic [MISS_W-1:0] miss_d;
    state_t            state_q;
    state_t            state_d;

    logic fire;
    logic is_sync;
    logic at_wrap;
    logic on_time;
    logic early;
    logic miss_ev;

    assign fire    = v_reg & en_reg;
    assign is_sync = fire & (in_reg == SYNC_WORD);
    assign at_wrap = (cnt == CNT_LAST);
    assign on_time = is_sync & at_wrap;
    assign early   = is_sync & ~at_wrap;
    assign miss_ev = fire & ~is_sync & at_wrap;

    assign bus.locked = (state_q == LOCKED);

    // Input register stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_reg <= '0;
            v_reg  <= 1'b0;
            en_reg <= 1'b0;
        end else begin
            in_reg <= bus.in;
            v_reg  <= bus.in_valid;
            en_reg <= bus.descram_en;
        end
    end

    // Sixteen serial LFSR steps unrolled: keystream and next state.
    always_comb begin
        s_adv = s;
        ks    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ks[i] = s_adv[WIDTH-1];
            s_adv = {s_adv[WIDTH-2:0], 1'b0}
                  ^ (s_adv[WIDTH-1] ? TAPS : '0);
        end
    end

    // LFSR state and frame counter advance only on descrambled words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s   <= SEED;
            cnt <= '0;
        end else if (fire) begin
            if (is_sync) begin
                s   <= SEED;
                cnt <= '0;
            end else begin
                s   <= s_adv;
                cnt <= at_wrap ? '0 : cnt + CNT_W'(1);
            end
        end
    end

    // Output word register; holds its value across invalid cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
            bus.sync_det  <= 1'b0;
        end else begin
            bus.out_valid <= v_reg;
            bus.sync_det  <= is_sync;
            if (v_reg) begin
                if (!en_reg || is_sync) begin
                    bus.out <= in_reg;
                end else begin
                    bus.out <= in_reg ^ ks;
                end
            end
        end
    end

    // Framing state and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
            good_q  <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            miss_q  <= miss_d;
        end
    end

    // Framing next-state on sync timing events.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        miss_d  = miss_q;
        unique case (state_q)
            HUNT: begin
                if (is_sync) begin
                    state_d = VERIFY;
                    good_d  = GOOD_W'(1);
                end
            end
            VERIFY: begin
                if (on_time) begin
                    good_d = good_q + GOOD_W'(1);
                    if (good_d == GOOD_LOCK) begin
                        state_d = LOCKED;
                        miss_d  = '0;
                    end
                end else if (early) begin
                    good_d = GOOD_W'(1);
                end else if (miss_ev) begin
                    state_d = HUNT;
                    good_d  = '0;
                end
            end
            LOCKED: begin
                if (on_time) begin
                    miss_d = '0;
                end else if (early || miss_ev) begin
                    miss_d = miss_q + MISS_W'(1);
                    if (miss_d == MISS_LOSS) begin
                        state_d = HUNT;
                        good_d  = '0;
                        miss_d  = '0;
                    end
                end
            end
            default: begin
                state_d = HUNT;
                good_d  = '0;
                miss_d  = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_descrambler.sv
// tb_descrambler: directed and randomized frames checked against
// a keystream-table and frame-position reference model.
module tb_descrambler;
    localparam logic [15:0] SYNC = 16'hBCBC;
    localparam int SI   = 8;
    localparam int LOCK = 3;
    localparam int LOSS = 2;
    localparam int NKS  = 256;

    typedef struct packed {
        logic        v;
        logic [15:0] o;
        logic        sd;
        logic        lk;
        logic        chk;
        logic [15:0] pay;
    } exp_t;

    logic clk;
    logic rst_n;

    descrambler_if #(.WIDTH(16)) bus ();

    descrambler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int compared;
    int mismatched;

    logic [15:0] ks_word [NKS];

    int          rx_idx;
    int          rx_pos;
    int          fsm;
    int          good;
    int          missc;
    logic [15:0] last_out;
    int          tx_idx;
    exp_t        prev;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keystream as a bit stream from seed FFFF: word n = bits 16n..16n+15.
    task automatic build_ks();
        logic [15:0] s;
        s = 16'hFFFF;
        for (int n = 0; n < NKS * 16; n++) begin
            ks_word[n / 16][n % 16] = s[15];
            s = (s << 1) ^ (s[15] ? 16'h0039 : 16'h0000);
        end
    endtask

    function automatic logic [15:0] ksw(input int idx);
        return ks_word[idx % NKS];
    endfunction

    task automatic model_reset();
        rx_idx   = 0;
        rx_pos   = 0;
        fsm      = 0;
        good     = 0;
        missc    = 0;
        last_out = 16'h0000;
        prev     = '0;
    endtask

    task automatic model(input logic en, input logic v,
                         input logic [15:0] d, input logic chk,
                         input logic [15:0] pay, output exp_t e);
        bit wrap;
        e     = '0;
        e.chk = chk;
        e.pay = pay;
        if (!v) begin
            e.o = last_out;
        end else if (!en) begin
            e.v      = 1'b1;
            e.o      = d;
            last_out = d;
        end else begin
            e.v  = 1'b1;
            wrap = (rx_pos == SI - 1);
            if (d == SYNC) begin
                e.o  = d;
                e.sd = 1'b1;
                if (fsm == 0) begin
                    fsm  = 1;
                    good = 1;
                end else if (fsm == 1) begin
                    if (wrap) begin
                        good++;
                        if (good >= LOCK) begin
                            fsm   = 2;
                            missc = 0;
                        end
                    end else begin
                        good = 1;
                    end
                end else begin
                    if (wrap) begin
                        missc = 0;
                    end else begin
                        missc++;
                        if (missc >= LOSS) begin
                            fsm   = 0;
                            good  = 0;
                            missc = 0;
                        end
                    end
                end
                rx_idx = 0;
                rx_pos = 0;
            end else begin
                e.o = d ^ ksw(rx_idx);
                rx_idx++;
                if (wrap) begin
                    if (fsm == 1) begin
                        fsm  = 0;
                        good = 0;
                    end else if (fsm == 2) begin
                        missc++;
                        if (missc >= LOSS) begin
                            fsm   = 0;
                            good  = 0;
                            missc = 0;
                        end
                    end
                end
                rx_pos = (rx_pos + 1) % SI;
            end
            last_out = e.o;
        end
        e.lk = (fsm == 2);
    endtask

    task automatic check(input exp_t e);
        compared++;
        assert (bus.out_valid === e.v) else begin
            mismatched++;
            $error("FAIL out_valid: got %b exp %b", bus.out_valid, e.v);
        end
        compared++;
        assert (bus.out === e.o) else begin
            mismatched++;
            $error("FAIL out: got %h exp %h", bus.out, e.o);
        end
        compared++;
        assert (bus.sync_det === e.sd) else begin
            mismatched++;
            $error("FAIL sync_det: got %b exp %b", bus.sync_det, e.sd);
        end
        compared++;
        assert (bus.locked === e.lk) else begin
            mismatched++;
            $error("FAIL locked: got %b exp %b", bus.locked, e.lk);
        end
        if (e.chk) begin
            compared++;
            assert (bus.out === e.pay) else begin
                mismatched++;
                $error("FAIL payload: got %h exp %h", bus.out, e.pay);
            end
        end
    endtask

    task automatic check_lock(input string tag, input logic exp_lk);
        compared++;
        assert (bus.locked === exp_lk) else begin
            mismatched++;
            $error("FAIL %s: locked got %b exp %b", tag, bus.locked, exp_lk);
        end
    endtask

    task automatic check_zero(input string tag);
        compared++;
        assert ({bus.out, bus.out_valid, bus.sync_det, bus.locked} === 19'h0)
        else begin
            mismatched++;
            $error("FAIL %s: out=%h ov=%b sd=%b lk=%b exp all 0", tag,
                   bus.out, bus.out_valid, bus.sync_det, bus.locked);
        end
    endtask

    task automatic step(input logic en, input logic v, input logic [15:0] d,
                        input logic chk, input logic [15:0] pay);
        exp_t e;
        bus.descram_en = en;
        bus.in_valid   = v;
        bus.in         = d;
        model(en, v, d, chk, pay, e);
        @(posedge clk);
        #1;
        check(prev);
        prev = e;
    endtask

    task automatic send_sync();
        step(1'b1, 1'b1, SYNC, 1'b0, 16'h0);
        tx_idx = 0;
    endtask

    task automatic send_bad_sync();
        step(1'b1, 1'b1, 16'h0000, 1'b0, 16'h0);
        tx_idx = 0;
    endtask

    task automatic send_pay(input logic [15:0] p, input logic chk);
        logic [15:0] d;
        d = p ^ ksw(tx_idx);
        if (d == SYNC) d = d ^ 16'h0001;
        if (d == (p ^ ksw(tx_idx))) begin
            step(1'b1, 1'b1, d, chk, p);
        end else begin
            step(1'b1, 1'b1, d, 1'b0, p);
        end
        tx_idx++;
    endtask

    task automatic gap();
        step(1'b1, 1'b0, 16'($urandom), 1'b0, 16'h0);
    endtask

    task automatic rand_payload(input int n, input logic chk, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) gap();
            send_pay(16'($urandom), chk);
        end
    endtask

    task automatic do_reset();
        bus.in_valid   = 1'b0;
        bus.descram_en = 1'b1;
        bus.in         = 16'h0;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("reset");
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        tx_idx = 0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        bus.in_valid   = 1'b0;
        bus.descram_en = 1'b0;
        bus.in         = 16'h0;
        build_ks();
        model_reset();
        tx_idx = 0;

        // Basic descramble
        do_reset();
        send_sync();
        step(1'b1, 1'b1, 16'h17FF, 1'b1, 16'h0000);
        gap();
        gap();

        // Round trip: 8 frames of sync + 7 random payload words
        do_reset();
        for (int f = 0; f < 8; f++) begin
            send_sync();
            rand_payload(SI - 1, 1'b1, 1'b0);
        end
        send_sync();
        gap();
        check_lock("roundtrip", 1'b1);

        // Loss of lock, then relock
        rand_payload(SI - 1, 1'b1, 1'b0);
        send_bad_sync();
        rand_payload(SI - 1, 1'b0, 1'b0);
        send_bad_sync();
        gap();
        check_lock("loss", 1'b0);
        rand_payload(SI - 1, 1'b0, 1'b0);
        for (int f = 0; f < 3; f++) begin
            send_sync();
            rand_payload(SI - 1, 1'b1, 1'b1);
        end
        send_sync();
        gap();
        check_lock("relock", 1'b1);

        // Early sync in VERIFY with good=2
        do_reset();
        send_sync();
        rand_payload(SI - 1, 1'b1, 1'b0);
        send_sync();
        rand_payload(4, 1'b1, 1'b0);
        send_sync();
        send_pay(16'h0000, 1'b1);
        rand_payload(SI - 2, 1'b1, 1'b0);
        send_sync();
        gap();
        check_lock("early_not_yet", 1'b0);
        rand_payload(SI - 1, 1'b1, 1'b0);
        send_sync();
        gap();
        check_lock("early_relock", 1'b1);

        // Bypass and stalls while locked
        rand_payload(3, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 16'h1234, 1'b1, 16'h1234);
            gap();
        end
        rand_payload(SI - 4, 1'b1, 1'b1);
        send_sync();
        gap();
        check_lock("bypass_hold", 1'b1);
        for (int f = 0; f < 2; f++) begin
            rand_payload(SI - 1, 1'b1, 1'b1);
            send_sync();
        end
        rand_payload(3, 1'b1, 1'b0);

        // Async reset mid-frame, then reacquire
        do_reset();
        check_lock("after_reset", 1'b0);
        rand_payload(2, 1'b0, 1'b0);
        send_sync();
        rand_payload(SI - 1, 1'b1, 1'b0);
        send_sync();
        rand_payload(SI - 1, 1'b1, 1'b0);
        send_sync();
        gap();
        check_lock("reacquire", 1'b1);
        gap();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
